// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for the pipelined carry adder: op encoding and
// the WIDTH/STAGES legality check used by the block and its bench.
package pipelined_carry_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // A pipeline needs at least two stages and equal-sized chunks.
  function automatic bit cfg_legal(input int width, input int stages);
    return (stages >= 2) && (width >= stages) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_adder_cla_slice.sv
// Combinational carry-lookahead slice of CHUNK bits.
// Ports: a, b, cin in; sum, cout (carry out of MSB), cmsb (carry into MSB) out.
module cla_slice
  import pipelined_carry_adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             t;

  // Every carry is a flat sum of products of generate/propagate terms,
  // so no carry waits on the carry below it.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    t = 1'b0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) begin
        t = t & p[j];
      end
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) begin
          t = t & p[m];
        end
        c[i+1] = c[i+1] | t;
      end
    end
    sum  = p ^ c[CHUNK-1:0];
    cout = c[CHUNK];
    cmsb = c[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// STAGES-deep add/subtract pipeline, one CHUNK-bit lookahead slice per stage,
// valid/ready on both sides with bubble collapsing.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, cin, op;
// out_valid/out_ready, sum, cout, ovf.
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_carry_adder: illegal WIDTH/STAGES");
  end

  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] free;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  // Subtraction is a + ~b + 1; cin only matters for addition.
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    cin_eff = (op == OP_SUB) ? 1'b1 : cin;
  end

  // free[k]: stage k can take new contents this cycle, either because
  // it is empty or because its contents move on.
  always_comb begin
    free    = '0;
    valid_d = valid_q;
    free[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      free[k] = !valid_q[k] || free[k+1];
    end
    if (free[0]) begin
      valid_d[0] = in_valid;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (free[k]) begin
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0]       sa;
    logic [CHUNK-1:0]       sb;
    logic [CHUNK-1:0]       ssum;
    logic                   scin;
    logic                   scout;
    logic                   ld;
    logic [(k+1)*CHUNK-1:0] sum_d;
    logic [(k+1)*CHUNK-1:0] sum_q;
    logic                   carry_d;
    logic                   carry_q;

    if (k == 0) begin : g_head
      always_comb begin
        sa      = a[CHUNK-1:0];
        sb      = b_eff[CHUNK-1:0];
        scin    = cin_eff;
        ld      = in_valid && free[0];
        sum_d   = ssum;
        carry_d = scout;
      end
    end else begin : g_body
      // Operand chunks arrive right-aligned from the previous stage.
      always_comb begin
        sa      = g_stage[k-1].g_ops.a_q[CHUNK-1:0];
        sb      = g_stage[k-1].g_ops.b_q[CHUNK-1:0];
        scin    = g_stage[k-1].carry_q;
        ld      = valid_q[k-1] && free[k];
        sum_d   = {ssum, g_stage[k-1].sum_q};
        carry_d = scout;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      logic cmsb;
      logic ovf_d;
      logic ovf_q;

      cla_slice #(
        .CHUNK (CHUNK)
      ) u_cla (
        .a    (sa),
        .b    (sb),
        .cin  (scin),
        .sum  (ssum),
        .cout (scout),
        .cmsb (cmsb)
      );

      always_comb begin
        ovf_d = cmsb ^ scout;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (ld) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_mid
      logic cmsb_unused;

      cla_slice #(
        .CHUNK (CHUNK)
      ) u_cla (
        .a    (sa),
        .b    (sb),
        .cin  (scin),
        .sum  (ssum),
        .cout (scout),
        .cmsb (cmsb_unused)
      );
    end

    // Upper operand chunks not yet added ride along with the transaction.
    if (k < STAGES - 1) begin : g_ops
      localparam int RW = WIDTH - (k + 1) * CHUNK;
      logic [RW-1:0] a_d;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_d;
      logic [RW-1:0] b_q;

      if (k == 0) begin : g_ld0
        always_comb begin
          a_d = a[WIDTH-1:CHUNK];
          b_d = b_eff[WIDTH-1:CHUNK];
        end
      end else begin : g_ldn
        always_comb begin
          a_d = g_stage[k-1].g_ops.a_q[RW+CHUNK-1:CHUNK];
          b_d = g_stage[k-1].g_ops.b_q[RW+CHUNK-1:CHUNK];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (ld) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  always_comb begin
    in_ready  = free[0];
    out_valid = valid_q[STAGES-1];
    sum       = g_stage[STAGES-1].sum_q;
    cout      = g_stage[STAGES-1].carry_q;
    ovf       = g_stage[STAGES-1].g_tail.ovf_q;
  end

endmodule
